// File: rtl/pipeline_reduce_pkg.sv
// Sizing helpers shared by the reduction tree and its output FIFO.
// Everything here is derived from the LANES / DATA_W / IMG_N parameters.
package pipeline_reduce_pkg;

    localparam int DEFAULT_LANES      = 60;
    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_IMG_N      = 258;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    // Ceiling log2; clogb2(1) = 0.
    function automatic int clogb2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int stages_f(input int lanes);
        return clogb2(lanes);
    endfunction

    function automatic int acc_w_f(input int data_w, input int lanes);
        return data_w + clogb2(lanes);
    endfunction

    // Number of registered nodes produced by stage s.
    function automatic int nodes_f(input int lanes, input int s);
        return (lanes + (1 << (s + 1)) - 1) >> (s + 1);
    endfunction

    function automatic int total_num_f(input int img_n);
        return img_n * img_n;
    endfunction

    function automatic int total_num_w_f(input int img_n);
        int w;
        w = clogb2(img_n * img_n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reduce_sync_fifo.sv
// First-word fall-through synchronous FIFO for summed pixels.
// Reports its free-entry count so the tree can reserve space before accepting a beat.
module reduce_sync_fifo
    import pipeline_reduce_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           head_data,
    output logic                        head_valid,
    output logic [clogb2(FIFO_DEPTH):0] free_cnt
);

    localparam int PTR_W = clogb2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid;
    // Head reads as zero while empty so the output is clean out of reset.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign free_cnt   = CNT_W'(FIFO_DEPTH) - count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_reduce_tree.sv
// Pipelined signed adder tree summing LANES masked lanes into one pixel per beat, with FIFO backpressure.
// Define REDUCE_SATURATE_EN to clamp the final sum to DATA_W instead of wrapping.
module pipeline_reduce_tree
    import pipeline_reduce_pkg::*;
#(
    parameter int LANES      = DEFAULT_LANES,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int IMG_N      = DEFAULT_IMG_N,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic                            start_calc,
    input  logic [LANES-1:0]                lane_mask,
    input  logic [LANES*DATA_W-1:0]         lane_data,
    input  logic                            lane_valid,
    output logic                            lane_ready,
    output logic [DATA_W-1:0]               wr_data,
    output logic                            wr_data_valid,
    input  logic                            wr_data_ready,
    output logic                            finish_calc,
    output logic [total_num_w_f(IMG_N)-1:0] pix_cnt,
    output logic                            overflow_err
);

    localparam int STAGES      = stages_f(LANES);
    localparam int ACC_W       = acc_w_f(DATA_W, LANES);
    localparam int TOTAL_NUM   = total_num_f(IMG_N);
    localparam int TOTAL_NUM_W = total_num_w_f(IMG_N);
    localparam int FREE_W      = clogb2(FIFO_DEPTH) + 1;

    logic                     accept;
    logic                     drop;
    logic                     handshake;
    logic [STAGES-1:0]        vld_q;
    logic [FREE_W-1:0]        in_flight;
    logic [FREE_W-1:0]        free_cnt;
    logic signed [ACC_W-1:0]  lane_ext [LANES];
    logic signed [ACC_W-1:0]  sum_full;
    logic [DATA_W-1:0]        sum_narrow;

    // A beat is only taken if its eventual FIFO slot is already reserved.
    assign lane_ready = (free_cnt > in_flight);
    assign accept     = lane_valid & lane_ready;
    assign drop       = lane_valid & ~lane_ready;
    assign handshake  = wr_data_valid & wr_data_ready;

    always_comb begin
        in_flight = '0;
        for (int s = 0; s < STAGES; s++) begin
            in_flight = in_flight + FREE_W'(vld_q[s]);
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_ext[k] = '0;
            if (lane_mask[k]) begin
                lane_ext[k] = ACC_W'($signed(lane_data[k*DATA_W +: DATA_W]));
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int N_IN  = (s == 0) ? LANES : nodes_f(LANES, s - 1);
        localparam int N_OUT = nodes_f(LANES, s);

        logic signed [ACC_W-1:0] src    [N_IN];
        logic signed [ACC_W-1:0] node_q [N_OUT];
        logic                    stage_ld;

        if (s == 0) begin : g_src
            assign src      = lane_ext;
            assign stage_ld = accept;
        end else begin : g_src
            assign src      = g_stage[s-1].node_q;
            assign stage_ld = vld_q[s-1];
        end

        for (genvar i = 0; i < N_OUT; i++) begin : g_node
            if (2*i + 1 < N_IN) begin : g_pair
                always_ff @(posedge clk or negedge arstn) begin
                    if (!arstn) begin
                        node_q[i] <= '0;
                    end else if (stage_ld) begin
                        node_q[i] <= src[2*i] + src[2*i+1];
                    end
                end
            end else begin : g_pass
                // Odd leftover entry rides through this stage unchanged.
                always_ff @(posedge clk or negedge arstn) begin
                    if (!arstn) begin
                        node_q[i] <= '0;
                    end else if (stage_ld) begin
                        node_q[i] <= src[2*i];
                    end
                end
            end
        end
    end

    assign sum_full = g_stage[STAGES-1].node_q[0];

`ifdef REDUCE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(STAGES+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(STAGES+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        sum_narrow = sum_full[DATA_W-1:0];
        if (sum_full > SAT_MAX) begin
            sum_narrow = SAT_MAX[DATA_W-1:0];
        end else if (sum_full < SAT_MIN) begin
            sum_narrow = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    // Plain two's-complement wrap; growth bits are intentionally dropped.
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_full[ACC_W-1:DATA_W];
    assign sum_narrow    = sum_full[DATA_W-1:0];
`endif

    reduce_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arstn      (arstn),
        .push       (vld_q[STAGES-1]),
        .push_data  (sum_narrow),
        .pop        (wr_data_ready),
        .head_data  (wr_data),
        .head_valid (wr_data_valid),
        .free_cnt   (free_cnt)
    );

    // start_calc takes priority over a same-cycle handshake when restarting the count.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pix_cnt      <= '0;
            finish_calc  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            finish_calc  <= 1'b0;
            overflow_err <= (overflow_err & ~start_calc) | drop;
            if (start_calc) begin
                pix_cnt <= '0;
            end else if (handshake) begin
                if (pix_cnt == TOTAL_NUM_W'(TOTAL_NUM - 1)) begin
                    pix_cnt     <= '0;
                    finish_calc <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + TOTAL_NUM_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_reduce_tree.sv
// Randomised bench for pipeline_reduce_tree against a queue-based reference of accepted beats.
// Honours REDUCE_SATURATE_EN in its reference so either build can be checked.
module tb_pipeline_reduce_tree;

    localparam int LANES      = 60;
    localparam int DATA_W     = 32;
    localparam int IMG_N      = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int STAGES     = 6;
    localparam int TOTAL      = IMG_N * IMG_N;

    logic                    clk = 1'b0;
    logic                    arstn = 1'b0;
    logic                    start_calc = 1'b0;
    logic [LANES-1:0]        lane_mask = '1;
    logic [LANES*DATA_W-1:0] lane_data = '0;
    logic                    lane_valid = 1'b0;
    logic                    lane_ready;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_data_valid;
    logic                    wr_data_ready = 1'b0;
    logic                    finish_calc;
    logic [3:0]              pix_cnt;
    logic                    overflow_err;

    always #5 clk = ~clk;

    pipeline_reduce_tree #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .IMG_N      (IMG_N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .start_calc    (start_calc),
        .lane_mask     (lane_mask),
        .lane_data     (lane_data),
        .lane_valid    (lane_valid),
        .lane_ready    (lane_ready),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .finish_calc   (finish_calc),
        .pix_cnt       (pix_cnt),
        .overflow_err  (overflow_err)
    );

    typedef struct {
        logic [31:0] val;
        int          due;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    m_pix   = 0;
    logic  m_fin   = 1'b0;
    logic  m_ovf   = 1'b0;
    int    dut_fin = 0;
    int    first_valid_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_sum();
        longint s;
        s = 0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_mask[k]) s += longint'($signed(lane_data[k*DATA_W +: DATA_W]));
        end
`ifdef REDUCE_SATURATE_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic head_due();
        return (q.size() > 0) && (q[0].due <= cyc);
    endfunction

    task automatic check_outputs();
        logic ev;
        ev = head_due();
        if (finish_calc) dut_fin++;
        if (wr_data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        chk("lane_ready", lane_ready, q.size() < FIFO_DEPTH);
        chk("wr_data_valid", wr_data_valid, ev);
        if (ev) chk("wr_data", wr_data, q[0].val);
        chk("pix_cnt", pix_cnt, m_pix);
        chk("finish_calc", finish_calc, m_fin);
        chk("overflow_err", overflow_err, m_ovf);
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_valid"}, wr_data_valid, 1'b0);
        chk({tag, "_data"}, wr_data, 32'h0);
        chk({tag, "_finish"}, finish_calc, 1'b0);
        chk({tag, "_pix"}, pix_cnt, 4'h0);
        chk({tag, "_ovf"}, overflow_err, 1'b0);
    endtask

    // Advance one clock: apply the reference rules to the inputs now driven, then check.
    task automatic tick();
        logic  acc;
        logic  pop;
        beat_t b;
        acc   = lane_valid && (q.size() < FIFO_DEPTH);
        pop   = head_due() && wr_data_ready;
        m_fin = 1'b0;
        if (pop) q.delete(0);
        if (start_calc) begin
            m_pix = 0;
        end else if (pop) begin
            if (m_pix == TOTAL - 1) begin
                m_pix = 0;
                m_fin = 1'b1;
            end else begin
                m_pix++;
            end
        end
        m_ovf = (m_ovf && !start_calc) || (lane_valid && !acc);
        if (acc) begin
            b.val = ref_sum();
            b.due = cyc + STAGES + 1;
            q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int k = 0; k < LANES; k++) lane_data[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < LANES; k++) lane_data[k*DATA_W +: DATA_W] = $urandom;
    endtask

    task automatic drain(input string tag);
        lane_valid    = 1'b0;
        wr_data_ready = 1'b1;
        for (int i = 0; i < 80 && q.size() > 0; i++) tick();
        tick();
        chk(tag, q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int fin0;
        int beat0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_zero("reset");
        arstn = 1'b1;
        check_outputs();
        start_calc = 1'b1;
        tick();
        start_calc = 1'b0;

        // Equal lanes, full mask, first-output latency
        wr_data_ready = 1'b1;
        lane_mask     = '1;
        set_all(32'h0000_1000);
        lane_valid    = 1'b1;
        beat0         = cyc;
        first_valid_cyc = -1;
        repeat (10) tick();
        drain("drain_equal");
        chk("first_latency", first_valid_cyc - beat0, STAGES + 1);

        // Five active lanes with a negative term
        lane_mask = '0;
        lane_mask[4:0] = 5'b11111;
        rand_lanes();
        lane_data[0*32 +: 32] = 32'd1;
        lane_data[1*32 +: 32] = 32'd2;
        lane_data[2*32 +: 32] = 32'd3;
        lane_data[3*32 +: 32] = 32'd4;
        lane_data[4*32 +: 32] = 32'hFFFF_FFEC;
        lane_valid = 1'b1;
        tick();

        // Single unmasked lane among large values
        lane_mask    = '0;
        lane_mask[0] = 1'b1;
        set_all(32'h7FFF_FFFF);
        lane_data[31:0] = 32'd7;
        tick();

        // All lanes at positive full scale
        lane_mask = '1;
        set_all(32'h7FFF_FFFF);
        repeat (2) tick();
        drain("drain_corner");

        // Stalled output with continuous input
        wr_data_ready = 1'b0;
        lane_valid    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rand_lanes();
            tick();
        end
        chk("ovf_after_stall", overflow_err, 1'b1);
        lane_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr_data_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain("drain_stall");
        wr_data_ready = 1'b0;
        start_calc    = 1'b1;
        tick();
        start_calc    = 1'b0;
        chk("ovf_cleared", overflow_err, 1'b0);

        // Exactly one frame of handshakes
        fin0          = dut_fin;
        wr_data_ready = 1'b1;
        lane_valid    = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            rand_lanes();
            tick();
        end
        drain("drain_frame");
        chk("frame_finish_pulses", dut_fin - fin0, 1);
        chk("frame_pix_wrap", pix_cnt, 4'h0);

        // Random traffic, masks and backpressure
        for (int i = 0; i < 400; i++) begin
            rand_lanes();
            for (int k = 0; k < LANES; k++) lane_mask[k] = ($urandom_range(0, 3) != 0);
            lane_valid    = ($urandom_range(0, 9) < 7);
            wr_data_ready = ($urandom_range(0, 9) < 6);
            start_calc    = !wr_data_ready && ($urandom_range(0, 49) == 0);
            tick();
            start_calc    = 1'b0;
        end
        drain("drain_random");

        // Reset in the middle of a frame
        lane_mask     = '1;
        wr_data_ready = 1'b1;
        lane_valid    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_lanes();
            tick();
        end
        lane_valid = 1'b0;
        #2;
        arstn = 1'b0;
        #1;
        check_reset_zero("midreset");
        q.delete();
        m_pix = 0;
        m_fin = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        cyc++;
        check_outputs();
        lane_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_lanes();
            tick();
        end
        drain("drain_after_reset");
        chk("pix_after_reset", pix_cnt, 4'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
